// File: rtl/fs_domain_ctrl_pkg.sv
// Shared types and constants for the fail-safe domain controller.
// State encoding doubles as the STATE register readback value.
package fs_domain_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_INIT   = 2'd1,
        ST_NORMAL = 2'd2,
        ST_SAFE   = 2'd3
    } fs_state_e;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_VCORE_TH = 8'h01;
    localparam logic [7:0] ADDR_VDDIO_TH = 8'h02;
    localparam logic [7:0] ADDR_VMON_TH  = 8'h03;
    localparam logic [7:0] ADDR_VMON_EN  = 8'h10;
    localparam logic [7:0] ADDR_SVS      = 8'h11;
    localparam logic [7:0] ADDR_FILT     = 8'h12;
    localparam logic [7:0] ADDR_STAT     = 8'h13;
    localparam logic [7:0] ADDR_REACT    = 8'h14;
    localparam logic [7:0] ADDR_STATE    = 8'h15;
    localparam logic [7:0] ADDR_WDKEY    = 8'h16;

    localparam int F_VCORE_OV  = 0;
    localparam int F_VCORE_UV  = 1;
    localparam int F_VDDIO_OV  = 2;
    localparam int F_VDDIO_UV  = 3;
    localparam int F_FCCU1     = 4;
    localparam int F_FCCU2     = 5;
    localparam int F_ERRMON    = 6;
    localparam int F_VMON_BASE = 7;

    localparam logic [11:0] WD_KEY = 12'h0A5;
    localparam logic [3:0]  TH_RST = 4'h8;

    function automatic int fault_width(input int nvmon);
        return F_VMON_BASE + 2 * nvmon;
    endfunction

endpackage

// File: rtl/fs_domain_ctrl_if.sv
// APB slave bus bundle for the fail-safe domain controller.
interface fs_domain_ctrl_if #(
    parameter int DATA_W = 15
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [7:0]        paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fs_domain_ctrl_filter.sv
// Single-channel fault deglitcher: saturating run-length counter
// compared against the programmed filter length.
module fs_fault_filter #(
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              raw_i,
    input  logic              en_i,
    input  logic [FILT_W-1:0] filt_i,
    output logic              flt_o
);
    logic [FILT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i && raw_i) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign flt_o = en_i & raw_i & (cnt_q >= filt_i);
endmodule

// File: rtl/fs_domain_ctrl.sv
// Fail-safe domain controller: deglitched fault capture, OFF/INIT/NORMAL/SAFE
// FSM and APB register file. Define FS_WDG_EN to add the WDKEY watchdog.
module fs_domain_ctrl
    import fs_domain_pkg::*;
#(
    parameter int UDLY     = 1,
    parameter int NVMON    = 4,
    parameter int FILT_W   = 4,
    parameter int INIT_TMO = 1024,
    parameter int WD_TMO   = 4096,
    parameter int DATA_W   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fs_enable,
    input  logic                 vcoremon_ov,
    input  logic                 vcoremon_uv,
    input  logic                 vddio_ov,
    input  logic                 vddio_uv,
    input  logic [NVMON-1:0]     vmonx_ov,
    input  logic [NVMON-1:0]     vmonx_uv,
    input  logic                 fccu1,
    input  logic                 fccu2,
    input  logic                 errmon,
    fs_domain_ctrl_if.slave      apb,
    output logic [3:0]           vcoreovth,
    output logic [3:0]           vcoreuvth,
    output logic [3:0]           vddioovth,
    output logic [3:0]           vddiouvth,
    output logic [4*NVMON-1:0]   vmon_ovth,
    output logic [4*NVMON-1:0]   vmon_uvth,
    output logic [NVMON-1:0]     vmon_en,
    output logic [4:0]           svs_offset,
    output logic                 dfs,
    output logic                 fs_ready,
    output logic                 valid_wd
);
    localparam int NF   = fault_width(NVMON);
    localparam int NTH  = NVMON + 2;
    localparam int IC_W = $clog2(INIT_TMO + 1);

    if (DATA_W < NF || NVMON < 1 || NVMON > 4 || FILT_W > DATA_W ||
        INIT_TMO < 2 || WD_TMO < 2 || UDLY < 0) begin : g_bad_cfg
        $error("fs_domain_ctrl: illegal parameter combination");
    end

    fs_state_e         state_q, state_d;
    logic [IC_W-1:0]   init_cnt_q, init_cnt_d;
    logic [3:0]        ov_th_q [NTH];
    logic [3:0]        uv_th_q [NTH];
    logic [NVMON-1:0]  vmon_en_q;
    logic [4:0]        svs_q;
    logic [FILT_W-1:0] filt_q;
    logic [NF-1:0]     stat_q, stat_d;
    logic [NF-1:0]     react_q;
    logic              lock_q;

    logic [NF-1:0]     raw, fen, flt, w1c;
    logic [7:0]        a;
    logic              acc, is_th, mapped, err, wr, go;
    logic              go_blk, stat_hit, wd_err;
    logic [DATA_W-1:0] rdata;

    // APB decode
    assign a     = apb.paddr;
    assign acc   = apb.psel & apb.penable;
    assign is_th = (a >= ADDR_VCORE_TH) && (a <= ADDR_VDDIO_TH + 8'(NVMON));

    always_comb begin
        mapped = is_th || (a == ADDR_CTRL) ||
                 ((a >= ADDR_VMON_EN) && (a <= ADDR_STATE));
`ifdef FS_WDG_EN
        if (a == ADDR_WDKEY) mapped = 1'b1;
`endif
    end

    assign err = acc & (~mapped | (apb.pwrite & lock_q & is_th));
    assign wr  = acc & apb.pwrite & ~err;
    assign go  = wr && (a == ADDR_CTRL) && apb.pwdata[0];
    assign w1c = (wr && (a == ADDR_STAT)) ? apb.pwdata[NF-1:0] : '0;

    assign apb.pready  = 1'b1;
    assign apb.pslverr = err;
    assign apb.prdata  = rdata;

    always_comb begin
        rdata = '0;
        if (apb.psel) begin
            for (int k = 0; k < NTH; k++) begin
                if (a == ADDR_VCORE_TH + 8'(k)) rdata[7:0] = {uv_th_q[k], ov_th_q[k]};
            end
            case (a)
                ADDR_CTRL:    rdata[1]          = lock_q;
                ADDR_VMON_EN: rdata[NVMON-1:0]  = vmon_en_q;
                ADDR_SVS:     rdata[4:0]        = svs_q;
                ADDR_FILT:    rdata[FILT_W-1:0] = filt_q;
                ADDR_STAT:    rdata[NF-1:0]     = stat_q;
                ADDR_REACT:   rdata[NF-1:0]     = react_q;
                ADDR_STATE:   rdata[2:0]        = {wd_err, state_q};
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NTH; k++) begin
                ov_th_q[k] <= TH_RST;
                uv_th_q[k] <= TH_RST;
            end
            vmon_en_q <= '0;
            svs_q     <= '0;
            filt_q    <= FILT_W'(3);
            react_q   <= '1;
            lock_q    <= 1'b0;
        end else if (wr) begin
            for (int k = 0; k < NTH; k++) begin
                if (a == ADDR_VCORE_TH + 8'(k)) begin
                    ov_th_q[k] <= apb.pwdata[3:0];
                    uv_th_q[k] <= apb.pwdata[7:4];
                end
            end
            case (a)
                ADDR_CTRL:    if (apb.pwdata[1]) lock_q <= 1'b1;
                ADDR_VMON_EN: vmon_en_q <= apb.pwdata[NVMON-1:0];
                ADDR_SVS:     svs_q     <= apb.pwdata[4:0];
                ADDR_FILT:    filt_q    <= apb.pwdata[FILT_W-1:0];
                ADDR_REACT:   react_q   <= apb.pwdata[NF-1:0];
                default:      ;
            endcase
        end
    end

    // Fault vector assembly; disabled VMON channels keep their filter idle
    always_comb begin
        raw = '0;
        fen = '1;
        raw[F_VCORE_OV] = vcoremon_ov;
        raw[F_VCORE_UV] = vcoremon_uv;
        raw[F_VDDIO_OV] = vddio_ov;
        raw[F_VDDIO_UV] = vddio_uv;
        raw[F_FCCU1]    = fccu1;
        raw[F_FCCU2]    = fccu2;
        raw[F_ERRMON]   = errmon;
        for (int i = 0; i < NVMON; i++) begin
            raw[F_VMON_BASE + 2*i]     = vmonx_ov[i];
            raw[F_VMON_BASE + 2*i + 1] = vmonx_uv[i];
            fen[F_VMON_BASE + 2*i]     = vmon_en_q[i];
            fen[F_VMON_BASE + 2*i + 1] = vmon_en_q[i];
        end
    end

    for (genvar g = 0; g < NF; g++) begin : g_flt
        fs_fault_filter #(
            .FILT_W (FILT_W)
        ) u_flt (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (raw[g]),
            .en_i   (fen[g]),
            .filt_i (filt_q),
            .flt_o  (flt[g])
        );
    end

    assign stat_d   = (stat_q & ~w1c) | flt;
    assign stat_hit = |(stat_q & react_q);
    assign go_blk   = |((stat_q | flt) & react_q);

    always_ff @(posedge clk) begin
        if (!rst_n) stat_q <= '0;
        else        stat_q <= stat_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign init_cnt_d = (state_q == ST_INIT) ? init_cnt_q + IC_W'(1) : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:    if (fs_enable) state_d = ST_INIT;
            ST_INIT: begin
                if (go)                                      state_d = go_blk ? ST_SAFE : ST_NORMAL;
                else if (init_cnt_q == IC_W'(INIT_TMO - 1)) state_d = ST_SAFE;
            end
            ST_NORMAL: if (stat_hit || wd_err) state_d = ST_SAFE;
            ST_SAFE:   if (go && !go_blk)      state_d = ST_NORMAL;
            default:   state_d = ST_OFF;
        endcase
        if (!fs_enable) state_d = ST_OFF;
    end

    always_comb begin
        dfs      = (state_q != ST_NORMAL);
        fs_ready = (state_q == ST_NORMAL);
        valid_wd = fs_ready & ~wd_err;
    end

`ifdef FS_WDG_EN
    localparam int WC_W = $clog2(WD_TMO + 1);

    logic [WC_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_err_q, wd_err_d;
    logic            go_ok;

    assign go_ok = fs_enable && go && !go_blk &&
                   (state_q == ST_INIT || state_q == ST_SAFE);

    always_comb begin
        wd_cnt_d = '0;
        wd_err_d = wd_err_q;
        if (state_q == ST_NORMAL) begin
            wd_cnt_d = wd_cnt_q + WC_W'(1);
            if (wr && (a == ADDR_WDKEY)) begin
                if (apb.pwdata == DATA_W'(WD_KEY)) wd_cnt_d = '0;
                else                               wd_err_d = 1'b1;
            end
            if (wd_cnt_q == WC_W'(WD_TMO - 1)) wd_err_d = 1'b1;
        end
        if (go_ok) wd_err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_err = 1'b0;
`endif

    assign vcoreovth  = ov_th_q[0];
    assign vcoreuvth  = uv_th_q[0];
    assign vddioovth  = ov_th_q[1];
    assign vddiouvth  = uv_th_q[1];
    assign vmon_en    = vmon_en_q;
    assign svs_offset = svs_q;

    for (genvar i = 0; i < NVMON; i++) begin : g_vth
        assign vmon_ovth[4*i +: 4] = ov_th_q[2 + i];
        assign vmon_uvth[4*i +: 4] = uv_th_q[2 + i];
    end
endmodule

// File: tb/tb_fs_domain_ctrl.sv
// Directed bench for fs_domain_ctrl: registers, deglitch, FSM, lock, watchdog.
module tb_fs_domain_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fs_enable = 1'b0;
    logic        vcoremon_ov = 1'b0, vcoremon_uv = 1'b0;
    logic        vddio_ov = 1'b0, vddio_uv = 1'b0;
    logic [3:0]  vmonx_ov = '0, vmonx_uv = '0;
    logic        fccu1 = 1'b0, fccu2 = 1'b0, errmon = 1'b0;
    logic [3:0]  vcoreovth, vcoreuvth, vddioovth, vddiouvth;
    logic [15:0] vmon_ovth, vmon_uvth;
    logic [3:0]  vmon_en;
    logic [4:0]  svs_offset;
    logic        dfs, fs_ready, valid_wd;

    int n_chk  = 0;
    int n_pass = 0;

    logic [14:0] rd;
    logic        er;

    fs_domain_ctrl_if #(.DATA_W(15)) apb ();

    fs_domain_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fs_enable   (fs_enable),
        .vcoremon_ov (vcoremon_ov),
        .vcoremon_uv (vcoremon_uv),
        .vddio_ov    (vddio_ov),
        .vddio_uv    (vddio_uv),
        .vmonx_ov    (vmonx_ov),
        .vmonx_uv    (vmonx_uv),
        .fccu1       (fccu1),
        .fccu2       (fccu2),
        .errmon      (errmon),
        .apb         (apb),
        .vcoreovth   (vcoreovth),
        .vcoreuvth   (vcoreuvth),
        .vddioovth   (vddioovth),
        .vddiouvth   (vddiouvth),
        .vmon_ovth   (vmon_ovth),
        .vmon_uvth   (vmon_uvth),
        .vmon_en     (vmon_en),
        .svs_offset  (svs_offset),
        .dfs         (dfs),
        .fs_ready    (fs_ready),
        .valid_wd    (valid_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic xfer(input bit w, input logic [7:0] ad, input logic [14:0] wd,
                        output logic [14:0] rdat, output logic e);
        @(negedge clk);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = w;
        apb.paddr   = ad;
        apb.pwdata  = wd;
        @(negedge clk);
        apb.penable = 1'b1;
        #1;
        rdat = apb.prdata;
        e    = apb.pslverr;
        @(posedge clk);
        #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
    endtask

    initial begin
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0;  apb.pwdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_dfs", dfs, 1);
        chk("rst_ready", fs_ready, 0);
        chk("rst_vwd", valid_wd, 0);
        chk("rst_vcoreov", vcoreovth, 4'h8);
        chk("rst_vmonuv", vmon_uvth, 16'h8888);
        chk("rst_vmon_en", vmon_en, 0);
        chk("rst_svs", svs_offset, 0);
        chk("prdata_idle", apb.prdata, 0);
        xfer(0, 8'h01, 0, rd, er); chk("rd_vcore_th", rd, 15'h88);
        xfer(0, 8'h02, 0, rd, er); chk("rd_vddio_th", rd, 15'h88);
        xfer(0, 8'h06, 0, rd, er); chk("rd_vmon3_th", rd, 15'h88);
        xfer(0, 8'h12, 0, rd, er); chk("rd_filt", rd, 3);
        xfer(0, 8'h14, 0, rd, er); chk("rd_react", rd, 15'h7FFF);
        xfer(0, 8'h13, 0, rd, er); chk("rd_stat", rd, 0);
        xfer(0, 8'h15, 0, rd, er); chk("rd_state_off", rd, 0);
        xfer(0, 8'h00, 0, rd, er); chk("rd_ctrl", rd, 0);

        // OFF -> INIT -> NORMAL
        fs_enable = 1'b1;
        xfer(0, 8'h15, 0, rd, er); chk("state_init", rd, 1);
        chk("init_dfs", dfs, 1);
        xfer(1, 8'h00, 15'h1, rd, er); chk("go_err", er, 0);
        @(negedge clk);
        chk("normal_dfs", dfs, 0);
        chk("normal_ready", fs_ready, 1);
        chk("normal_vwd", valid_wd, 1);

        // Glitch of 3 cycles is rejected
        @(negedge clk) vddio_uv = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) vddio_uv = 1'b0;
        xfer(0, 8'h13, 0, rd, er); chk("glitch_stat", rd, 0);
        chk("glitch_dfs", dfs, 0);

        // 4 cycles is a fault; SAFE one edge after STAT
        @(negedge clk) vddio_uv = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) chk("pre_safe_dfs", dfs, 0);
        @(posedge clk);
        @(negedge clk);
        chk("safe_dfs", dfs, 1);
        chk("safe_ready", fs_ready, 0);
        xfer(0, 8'h13, 0, rd, er); chk("fault_stat", rd, 15'h0008);
        xfer(0, 8'h15, 0, rd, er); chk("state_safe", rd, 3);

        // Set wins over W1C; GO refused while fault pending
        xfer(1, 8'h13, 15'h0008, rd, er);
        xfer(0, 8'h13, 0, rd, er); chk("set_wins", rd, 15'h0008);
        xfer(1, 8'h00, 15'h1, rd, er);
        xfer(0, 8'h15, 0, rd, er); chk("go_blocked", rd, 3);
        vddio_uv = 1'b0;
        xfer(1, 8'h13, 15'h0008, rd, er);
        xfer(0, 8'h13, 0, rd, er); chk("w1c_clear", rd, 0);
        xfer(1, 8'h00, 15'h1, rd, er);
        xfer(0, 8'h15, 0, rd, er); chk("recover", rd, 2);
        chk("recover_dfs", dfs, 0);

        // Threshold writes, lock, unmapped
        xfer(1, 8'h01, 15'h3C, rd, er);
        chk("vcore_ov_w", vcoreovth, 4'hC);
        chk("vcore_uv_w", vcoreuvth, 4'h3);
        xfer(1, 8'h05, 15'hA7, rd, er);
        chk("vmon2_ov_w", vmon_ovth[11:8], 4'h7);
        chk("vmon2_uv_w", vmon_uvth[11:8], 4'hA);
        xfer(1, 8'h00, 15'h2, rd, er); chk("lock_err", er, 0);
        xfer(1, 8'h03, 15'h55, rd, er); chk("locked_err", er, 1);
        xfer(0, 8'h03, 0, rd, er); chk("locked_val", rd, 15'h88);
        xfer(0, 8'h00, 0, rd, er); chk("rd_lock", rd, 15'h2);
        xfer(1, 8'h1F, 15'h1, rd, er); chk("unmapped_w", er, 1);
        xfer(1, 8'h11, 15'h15, rd, er);
        chk("svs_err", er, 0);
        chk("svs_val", svs_offset, 5'h15);
        chk("still_normal", fs_ready, 1);

`ifdef FS_WDG_EN
        xfer(1, 8'h16, 15'h0A5, rd, er); chk("wdkey_err", er, 0);
        chk("wd_valid", valid_wd, 1);
        repeat (4100) @(posedge clk);
        @(negedge clk);
        chk("wd_expired", valid_wd, 0);
        chk("wd_safe_dfs", dfs, 1);
        xfer(0, 8'h15, 0, rd, er); chk("wd_state", rd, 7);
`else
        xfer(1, 8'h16, 15'h0A5, rd, er); chk("wdkey_unmapped", er, 1);
        xfer(0, 8'h15, 0, rd, er); chk("wd_err_rd", rd, 2);
        chk("vwd_follow", valid_wd, 1);
`endif

        // fs_enable low forces OFF
        fs_enable = 1'b0;
        xfer(0, 8'h15, 0, rd, er); chk("state_off", rd, 0);
        chk("off_dfs", dfs, 1);

        // FILT=0 and VMON enable gating
        vmonx_ov = 4'b0010;
        xfer(1, 8'h12, 15'h0, rd, er);
        repeat (3) @(posedge clk);
        xfer(0, 8'h13, 0, rd, er); chk("vmon_gated", rd, 0);
        xfer(1, 8'h10, 15'h2, rd, er); chk("vmon_en_w", vmon_en, 4'h2);
        xfer(0, 8'h13, 0, rd, er); chk("vmon1_ov_stat", rd, 15'h0200);

        // Reset clears everything, including LOCK
        vmonx_ov = '0;
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        xfer(0, 8'h13, 0, rd, er); chk("rst2_stat", rd, 0);
        xfer(0, 8'h01, 0, rd, er); chk("rst2_vcore", rd, 15'h88);
        xfer(0, 8'h00, 0, rd, er); chk("rst2_lock", rd, 0);
        xfer(0, 8'h12, 0, rd, er); chk("rst2_filt", rd, 3);

        // INIT timeout without GO
        fs_enable = 1'b1;
        repeat (1030) @(posedge clk);
        xfer(0, 8'h15, 0, rd, er); chk("init_tmo", rd, 3);
        chk("init_tmo_dfs", dfs, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fs_domain_ctrl.md
Name: fs_domain_ctrl

Overview:
- Parametrised fail-safe domain controller and successor to the fixed 4-VMON fail-safe domain.
- Per-channel digital deglitch on OV/UV, FCCU and errmon fault inputs, with sticky W1C fault status.
- Programmable reaction mask and an OFF/INIT/NORMAL/SAFE state machine driving dfs and fs_ready.
- APB register file holds all monitor thresholds, VMON enables and SVS offset; it sits between the analog monitor comparators and the system APB bus.

Parameters:
- UDLY, 1, simulation-only assignment delay.
- NVMON, 4, number of external VMON channels, 1..4.
- FILT_W, 4, deglitch counter width.
- INIT_TMO, 1024, INIT-state timeout in clk cycles.
- WD_TMO, 4096, watchdog timeout in clk cycles (FS_WDG_EN only).
- DATA_W, 15, APB data width; must be ≥ 7+2*NVMON, checked at elaboration.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- fs_enable  in  1  fail-safe domain enable.
- vcoremon_ov, vcoremon_uv, vddio_ov, vddio_uv  in  1 each  raw comparator flags.
- vmonx_ov, vmonx_uv  in  NVMON each  raw VMON comparator flags.
- fccu1, fccu2, errmon  in  1 each  external fault requests, active high.
- psel, penable, pwrite  in  1  APB control.
- paddr  in  8  APB word address.
- pwdata  in  DATA_W  APB write data.
- prdata  out  DATA_W  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- vcoreovth, vcoreuvth, vddioovth, vddiouvth  out  4 each  thresholds.
- vmon_ovth, vmon_uvth  out  4*NVMON each  packed per-channel thresholds; channel i is bits [4i+3:4i].
- vmon_en  out  NVMON  VMON monitoring enables.
- svs_offset  out  5  static voltage scaling offset.
- dfs  out  1  fail-safe assertion, high = safe.
- fs_ready  out  1  domain operational.
- valid_wd  out  1  watchdog healthy.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State is OFF.
  - dfs=1, fs_ready=0, valid_wd=0.
  - All thresholds 4'h8, vmon_en=0, svs_offset=0.
  - FILT=3, REACT=all ones, STAT=0, LOCK=0.
  - Reset applies mid-transfer and mid-filter with no residue.
- Fault vector: 7+2*NVMON bits.
  - Bits 0..6: vcore_ov, vcore_uv, vddio_ov, vddio_uv, fccu1, fccu2, errmon.
  - Bit 7+2i: vmon i OV; bit 8+2i: vmon i UV.
- Deglitch (per bit):
  - The counter increments while the raw input is high, clears when it is low, and saturates at all ones.
  - The filtered fault is true when raw=1 and count ≥ FILT; FILT=0 gives a one-cycle latency to STAT.
  - VMON bits with vmon_en[i]=0 hold their counter at 0.
- STAT:
  - A sticky bit sets on a filtered fault.
  - Writing 1 clears the bit. If a set and a W1C clear land in the same cycle, set wins.
- FSM:
  - Any state with fs_enable=0 → OFF.
  - OFF (dfs=1, fs_ready=0): fs_enable=1 → INIT, init counter cleared.
  - INIT (dfs=1, fs_ready=0):
    - CTRL.GO write while (STAT & REACT)==0 → NORMAL.
    - Counter reaching INIT_TMO-1 without GO → SAFE.
  - NORMAL (dfs=0, fs_ready=1): (STAT & REACT)≠0 → SAFE on the next edge.
  - SAFE (dfs=1, fs_ready=0): exits only to NORMAL, on GO with (STAT & REACT)==0.
  - A fault and GO in the same cycle give SAFE.
  - Outputs are registered directly from the state.
- APB:
  - pready is always 1 (zero wait states).
  - A write commits on the edge with psel&penable&pwrite.
  - prdata is combinational from paddr when psel=1, else 0.
  - Unmapped address, or a threshold write with LOCK=1 → pslverr=1 in the access phase, with no write.
- Register map:
  - 0x00 CTRL: [0] GO, write-only pulse, reads 0. [1] LOCK, set-only.
  - 0x01 VCORE_TH: [3:0] ov, [7:4] uv.
  - 0x02 VDDIO_TH: [3:0] ov, [7:4] uv.
  - 0x03+i VMONi_TH, for i<NVMON: [3:0] ov, [7:4] uv.
  - 0x10 VMON_EN.
  - 0x11 SVS: [4:0].
  - 0x12 FILT.
  - 0x13 STAT, W1C.
  - 0x14 REACT.
  - 0x15 STATE, read-only: [1:0] FSM state, [2] wd_err.
  - Unused bits read 0.

Optional Feature:
- FS_WDG_EN defined:
  - Adds WDKEY at 0x16. A write of 0x0A5 in NORMAL reloads the WD_TMO counter; any other value sets wd_err.
  - Counter expiry in NORMAL sets wd_err.
  - While wd_err=1: valid_wd=0 and the FSM goes to SAFE.
  - wd_err clears on a GO that succeeds.
  - valid_wd=1 in NORMAL with wd_err=0, otherwise 0.
- FS_WDG_EN undefined:
  - 0x16 is unmapped.
  - valid_wd=1 when fs_ready=1.
  - wd_err reads 0.

Decomposition:
- Package fs_domain_pkg: state enum (OFF/INIT/NORMAL/SAFE), register address localparams, fault bit indices, WD key 0x0A5, threshold reset value 4'h8.
- Sub-module fs_fault_filter: one counter, raw/enable/FILT in, filtered out. Instantiated 7+2*NVMON times in a generate loop.

Test Plan:
- Reset, read all registers → thresholds 0x88, FILT=3, REACT=0x7FFF, STAT=0; dfs=1, fs_ready=0.
- fs_enable=1, write GO within 100 cycles → NORMAL; dfs=0 and fs_ready=1 one edge after the write.
- In NORMAL, vddio_uv high 3 cycles then low → STAT unchanged. High 4 cycles → STAT[3]=1, dfs=1 on the next edge.
- In SAFE with vddio_uv still high: W1C of 0x0008 leaves STAT[3]=1 (set wins). Deassert the input, W1C, then GO → NORMAL.
- Set LOCK, write 0x03 → pslverr=1 and value unchanged. Write to 0x1F → pslverr=1.
- With FS_WDG_EN: no WDKEY for 4096 cycles → valid_wd=0, SAFE. Without it: 0x16 write → pslverr=1.
